// File: rtl/ram_dp_model.sv
// Dual-port RAM: port 0 read/write with byte lanes, port 1 read-only.
// Clears the whole array after reset; BUSY is high while clearing.
//
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RST_N  synchronous active-low reset
//   EN0    port 0 enable
//   WE0    port 0 byte-lane write enables (bit i -> Di0[8i+7:8i])
//   A0     port 0 address
//   Di0    port 0 write data
//   Do0    port 0 read data
//   EN1    port 1 enable
//   A1     port 1 address
//   Do1    port 1 read data
//   BUSY   memory clear in progress
module ram_dp_model #(
  parameter int WSIZE      = 2,
  parameter int AW         = 8,
  parameter int READ_FIRST = 1,
  parameter int OUT_REG    = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN0,
  input  logic [WSIZE-1:0]   WE0,
  input  logic [AW-1:0]      A0,
  input  logic [8*WSIZE-1:0] Di0,
  output logic [8*WSIZE-1:0] Do0,
  input  logic               EN1,
  input  logic [AW-1:0]      A1,
  output logic [8*WSIZE-1:0] Do1,
  output logic               BUSY
);

  localparam int DW    = 8 * WSIZE;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_clr;
  logic          w_wr;
  logic          w_rd0;
  logic          w_rd1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] w_old0;
  logic [DW-1:0] w_old1;
  logic [DW-1:0] w_new0;
  logic [DW-1:0] w_new1;
  logic          w_hit1;

  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_clr     = 1'b0;
    w_wr      = 1'b0;
    w_rd0     = 1'b0;
    w_rd1     = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == {AW{1'b1}})
          w_next = READY;
      end
      READY: begin
        w_wr  = EN0 && (|WE0);
        w_rd0 = EN0;
        w_rd1 = EN1;
      end
      default: w_next = CLEAR;
    endcase
  end

  assign BUSY   = (r_state == CLEAR);
  assign w_old0 = r_mem[A0];
  assign w_old1 = r_mem[A1];
  assign w_hit1 = w_wr && (A1 == A0);

  // Byte-merged views: port 0's post-write word, and port 1's view
  // of the same word when it collides with a port 0 write.
  always_comb begin
    w_new0 = w_old0;
    w_new1 = w_old1;
    for (int i = 0; i < WSIZE; i++) begin
      if (WE0[i])
        w_new0[8*i +: 8] = Di0[8*i +: 8];
      if (w_hit1 && WE0[i])
        w_new1[8*i +: 8] = Di0[8*i +: 8];
    end
  end

  // Array itself has no reset; zeroing comes from the clear walk.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (w_clr)
        r_mem[r_cnt] <= '0;
      else if (w_wr)
        r_mem[A0] <= w_new0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_d0 <= '0;
      r_d1 <= '0;
    end else begin
      if (w_rd0)
        r_d0 <= (READ_FIRST != 0) ? w_old0 : w_new0;
      if (w_rd1)
        r_d1 <= (READ_FIRST != 0) ? w_old1 : w_new1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] r_q0;
      logic [DW-1:0] r_q1;
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_q0 <= '0;
          r_q1 <= '0;
        end else begin
          r_q0 <= r_d0;
          r_q1 <= r_d1;
        end
      end
      assign Do0 = r_q0;
      assign Do1 = r_q1;
    end else begin : g_noreg
      assign Do0 = r_d0;
      assign Do1 = r_d1;
    end
  endgenerate

endmodule
